program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 12 +
 rtl/program_loader.sv | 127 ++++++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants, FSM state type and header validation for the program loader.
package program_loader_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // A header is usable when it names between 1 and DEPTH words.
  function automatic logic hdr_ok(input logic [BYTE_W-1:0] n);
    return (n != '0) && (n <= BYTE_W'(DEPTH));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-serial valid/ready stream carrying the program image.
interface program_loader_if;
  import program_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/program_loader.sv
// Loads a checksummed program image from a byte stream into the instruction
// store and holds the CPU in reset until a load completes cleanly.
module program_loader
  import program_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  program_loader_if.slave    in_if,
  input  logic               restart_i,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [INSTR_W-1:0] mem_wdata_o,
  output logic               cpu_rst_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   words_loaded_o
);

  state_e               state_q;
  logic                 ready_q;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     words_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BYTE_W-1:0]    hi_q;
  logic [BYTE_W-1:0]    csum_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [INSTR_W-1:0]   mem_wdata_q;
  logic                 cpu_rst_q;
  logic                 done_q;
  logic                 err_q;
  logic                 accept_c;

  assign accept_c       = in_if.in_valid && ready_q;
  assign in_if.in_ready = ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

  // Load FSM with registered outputs; ready_q tracks the receiving states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      n_q         <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (hdr_ok(in_if.in_data)) begin
              n_q     <= CNT_W'(in_if.in_data);
              addr_q  <= '0;
              csum_q  <= '0;
              words_q <= '0;
              state_q <= ST_HI;
            end else begin
              ready_q <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end
          end
        end
        ST_HI: begin
          if (accept_c) begin
            hi_q    <= in_if.in_data;
            csum_q  <= csum_q ^ in_if.in_data;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (accept_c) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= {hi_q, in_if.in_data};
            csum_q      <= csum_q ^ in_if.in_data;
            addr_q      <= addr_q + ADDR_W'(1);
            words_q     <= words_q + CNT_W'(1);
            state_q     <= ((words_q + CNT_W'(1)) == n_q) ? ST_CHECK : ST_HI;
          end
        end
        ST_CHECK: begin
          if (accept_c) begin
            ready_q <= 1'b0;
            if (in_if.in_data == csum_q) begin
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERROR;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (restart_i) begin
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          ready_q   <= 1'b1;
          cpu_rst_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: per-cycle vector table plus
// hand-written multi-cycle sequences against a write log and memory model.
module tb_program_loader;
  import program_loader_pkg::*;

  logic               clk;
  logic               rst;
  logic               restart;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_rst;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   words_loaded;

  program_loader_if bus ();

  program_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_if          (bus),
    .restart_i      (restart),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .cpu_rst_o      (cpu_rst),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction store model and write log
  logic [15:0] mem_m [16];
  logic [3:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem_m[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, rs, v;
    logic [7:0] d;
    logic       rdy, we;
    logic [3:0] a;
    logic [15:0] wd;
    logic       crst, dn, er;
    logic [4:0] wl;
  } vec_t;

  vec_t vq [$];

  task automatic add(input logic rst_v, input logic rs_v, input logic v_v, input logic [7:0] d_v,
                     input logic rdy_e, input logic we_e, input logic [3:0] a_e,
                     input logic [15:0] wd_e, input logic crst_e, input logic dn_e,
                     input logic er_e, input logic [4:0] wl_e);
    vec_t t;
    t.rst = rst_v; t.rs = rs_v; t.v = v_v; t.d = d_v;
    t.rdy = rdy_e; t.we = we_e; t.a = a_e; t.wd = wd_e;
    t.crst = crst_e; t.dn = dn_e; t.er = er_e; t.wl = wl_e;
    vq.push_back(t);
  endtask

  task automatic check_outs(input string nm, input logic rdy_e, input logic we_e,
                            input logic [3:0] a_e, input logic [15:0] wd_e, input logic crst_e,
                            input logic dn_e, input logic er_e, input logic [4:0] wl_e);
    chk({nm, ".rdy"},  32'(bus.in_ready), 32'(rdy_e));
    chk({nm, ".we"},   32'(mem_we),       32'(we_e));
    chk({nm, ".addr"}, 32'(mem_addr),     32'(a_e));
    chk({nm, ".wd"},   32'(mem_wdata),    32'(wd_e));
    chk({nm, ".crst"}, 32'(cpu_rst),      32'(crst_e));
    chk({nm, ".done"}, 32'(done),         32'(dn_e));
    chk({nm, ".err"},  32'(err),          32'(er_e));
    chk({nm, ".wl"},   32'(words_loaded), 32'(wl_e));
  endtask

  // Present one byte, optionally after random idle gaps, and wait for acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
    end
    @(negedge clk);
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      bus.in_valid = 1'b0;
      waited++;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      chk("send_timeout", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    restart      = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    //   rst rs v  d      rdy we a  wd        crst dn er wl
    add(1, 0, 0, 8'h00,  1, 0, 0, 16'h0000, 1, 0, 0, 0);  // reset values
    add(0, 1, 0, 8'h00,  1, 0, 0, 16'h0000, 1, 0, 0, 0);  // restart ignored in IDLE
    add(0, 0, 1, 8'h02,  1, 0, 0, 16'h0000, 1, 0, 0, 0);  // good load
    add(0, 0, 1, 8'h04,  1, 0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 8'h50,  1, 1, 0, 16'h0450, 1, 0, 0, 1);
    add(0, 0, 1, 8'h12,  1, 0, 0, 16'h0450, 1, 0, 0, 1);
    add(0, 0, 1, 8'h34,  1, 1, 1, 16'h1234, 1, 0, 0, 2);
    add(0, 0, 1, 8'h72,  0, 0, 1, 16'h1234, 0, 1, 0, 2);
    add(0, 0, 1, 8'hFF,  0, 0, 1, 16'h1234, 0, 1, 0, 2);  // DONE ignores stream
    add(0, 1, 0, 8'h00,  1, 0, 1, 16'h1234, 1, 0, 0, 2);  // restart
    add(0, 0, 1, 8'h02,  1, 0, 1, 16'h1234, 1, 0, 0, 0);  // bad checksum
    add(0, 0, 1, 8'h04,  1, 0, 1, 16'h1234, 1, 0, 0, 0);
    add(0, 0, 1, 8'h50,  1, 1, 0, 16'h0450, 1, 0, 0, 1);
    add(0, 0, 1, 8'h12,  1, 0, 0, 16'h0450, 1, 0, 0, 1);
    add(0, 0, 1, 8'h34,  1, 1, 1, 16'h1234, 1, 0, 0, 2);
    add(0, 0, 1, 8'h73,  0, 0, 1, 16'h1234, 1, 0, 1, 2);
    add(0, 1, 0, 8'h00,  1, 0, 1, 16'h1234, 1, 0, 0, 2);
    add(0, 0, 1, 8'h00,  0, 0, 1, 16'h1234, 1, 0, 1, 2);  // header 0
    add(0, 1, 0, 8'h00,  1, 0, 1, 16'h1234, 1, 0, 0, 2);
    add(0, 0, 1, 8'h11,  0, 0, 1, 16'h1234, 1, 0, 1, 2);  // header 17
    add(0, 0, 1, 8'h05,  0, 0, 1, 16'h1234, 1, 0, 1, 2);  // ERROR ignores stream
    add(0, 1, 0, 8'h00,  1, 0, 1, 16'h1234, 1, 0, 0, 2);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst          = vq[i].rst;
      restart      = vq[i].rs;
      bus.in_valid = vq[i].v;
      bus.in_data  = vq[i].d;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].rdy, vq[i].we, vq[i].a, vq[i].wd,
                 vq[i].crst, vq[i].dn, vq[i].er, vq[i].wl);
    end
    idle_cycle();

    // Full depth with random backpressure: words 0x0000..0x000F, checksum 0x00
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h10, 2);
    for (int w = 0; w < 16; w++) begin
      send_byte(8'h00, 2);
      send_byte(8'(w), 2);
    end
    send_byte(8'h00, 2);
    idle_cycle();
    check_outs("full", 1'b0, 1'b0, 4'hF, 16'h000F, 1'b0, 1'b1, 1'b0, 5'd16);
    chk("full.nwrites", 32'(wr_addr_q.size()), 32'd16);
    for (int w = 0; w < 16 && w < wr_addr_q.size(); w++) begin
      chk($sformatf("full.waddr%0d", w), 32'(wr_addr_q[w]), 32'(w));
      chk($sformatf("full.wdata%0d", w), 32'(wr_data_q[w]), 32'(w));
    end

    // Restart after DONE, then reset after three payload bytes
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    chk("rs.rdy",  32'(bus.in_ready), 32'd1);
    chk("rs.crst", 32'(cpu_rst),      32'd1);
    chk("rs.done", 32'(done),         32'd0);
    @(negedge clk);
    restart = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    check_outs("midrst", 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("midrst.nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("midrst.waddr", 32'(wr_addr_q[0]), 32'd0);
      chk("midrst.wdata", 32'(wr_data_q[0]), 32'h0000AABB);
    end
    chk("midrst.mem1_kept", 32'(mem_m[1]), 32'h00000001);
    idle_cycle();
    chk("midrst.hold_crst", 32'(cpu_rst), 32'd1);

    // Idle stream for 10 cycles in the middle of the second word
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'h04, 0);
    send_byte(8'h50, 0);
    send_byte(8'h12, 0);
    for (int c = 0; c < 10; c++) begin
      idle_cycle();
      chk($sformatf("idle%0d.we", c),  32'(mem_we),       32'd0);
      chk($sformatf("idle%0d.rdy", c), 32'(bus.in_ready), 32'd1);
      chk($sformatf("idle%0d.wl", c),  32'(words_loaded), 32'd1);
    end
    send_byte(8'h34, 0);
    send_byte(8'h72, 0);
    idle_cycle();
    check_outs("idle_end", 1'b0, 1'b0, 4'h1, 16'h1234, 1'b0, 1'b1, 1'b0, 5'd2);
    chk("idle_end.nwrites", 32'(wr_addr_q.size()), 32'd2);
    chk("idle_end.mem0", 32'(mem_m[0]), 32'h00000450);
    chk("idle_end.mem1", 32'(mem_m[1]), 32'h00001234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
